prng_arbiter: RTL and testbench
===============================

# prng_arbiter

Shares one 32-bit Fibonacci LFSR random-number source between `NUM_REQ` requesters. It sequences the LFSR through a fixed number of shifts per output word, so consecutive words do not overlap. Each finished word is granted to exactly one requester, selected round-robin. Software can reseed the LFSR at any time. The block sits between the PRNG datapath and the crypto engines that consume nonces and masks.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `SHIFTS`, 32: LFSR shifts per output word (1..32).
- `SEED`, 32'd13: reset seed. Also substituted whenever a zero seed is loaded.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `req` in NUM_REQ: level request per requester. Held until that requester's `ack`.
- `ack` out NUM_REQ: one-hot, one-cycle grant pulse. `rnd_data` is valid in the same cycle.
- `rnd_data` out 32: granted random word. Held until the next grant.
- `seed_load` in 1: one-cycle pulse that reseeds the LFSR.
- `seed_data` in 32: new seed, sampled when `seed_load` = 1.
- `word_ready` out 1: a fresh word is buffered and waiting for a requester.
- `words_issued` out 16: count of grants since reset. Wraps from 16'hFFFF to 0.

## Operation
- LFSR step: `next = {l[31]^l[21]^l[1]^l[0], l[31:1]}`. The state never becomes zero.
- The state machine has two states, FILL and READY.
- **FILL:**
  - The LFSR shifts once per cycle and the shift counter increments from 0.
  - When the counter reaches SHIFTS-1, the shift on that edge is the last one. The post-shift LFSR value is captured into the word buffer, the counter clears, and the state moves to READY.
- **READY:**
  - The LFSR holds and `word_ready` = 1.
  - On an edge where any `req` bit is 1:
    - Pick the first asserted requester starting at pointer `rr` and searching upward with wrap.
    - Register `ack[i]` = 1 and `rnd_data` = buffer.
    - Set `rr` = (i+1) mod NUM_REQ.
    - Increment `words_issued` and go to FILL.
  - If no `req` bit is set, stay in READY indefinitely.
- `req` is ignored in FILL.
- **Reseed:**
  - `seed_load` = 1 is honoured in either state and has priority over everything else.
  - The LFSR loads `seed_data`, or `SEED` if `seed_data` = 0.
  - The buffered word is discarded, the counter clears, and the state moves to FILL.
  - No `ack` is issued on that edge, even if a grant was pending.
  - `rr` and `words_issued` are unchanged.
- **Reset** (asynchronous, at any point):
  - LFSR = `SEED`, state = FILL, counter = 0, `rr` = 0.
  - `ack` = 0, `rnd_data` = 0, `word_ready` = 0, `words_issued` = 0.
  - Any in-progress word is lost.

## Timing
- Fill latency is exactly SHIFTS cycles.
  - After reset deasserts, `word_ready` rises after the SHIFTS-th rising edge (edge 32 at default).
- Grant latency: `ack` is asserted one cycle after the edge that samples `req` in READY.
  - With `req` held from reset, `ack` is first high after edge 33.
- Minimum spacing between grants is SHIFTS+1 cycles.
- `ack` is never high for two consecutive cycles and never has more than one bit set.
- `word_ready` falls on the same edge that raises `ack`.
- A requester must drop `req` in the cycle after it sees `ack`. FILL ignores `req`, so no double grant can occur.
- `seed_load` in the cycle before a grant would have occurred wins. The next possible `ack` comes SHIFTS+1 edges after the seed edge.

## Structure
- Package `prng_pkg`:
  - `LFSR_W` = 32.
  - Tap constant set {31, 21, 1, 0}.
  - `DEFAULT_SEED` = 32'd13.
  - State enum {FILL, READY}.
- Sub-module `lfsr32_core` contains the LFSR register, the step function and zero-seed substitution.
  - Ports: `clock`, `reset`, `shift_en`, `load`, `load_data`, `state`.
- The top level contains the FSM, shift counter, word buffer, round-robin picker, and the `ack`/`rnd_data` registers.

## Test plan
- **Reset then single requester:** `req[2]` held from reset.
  - `ack` = 4'b0100 after edge 33.
  - `rnd_data` equals the golden model after 32 shifts from 13.
  - `words_issued` = 1.
- **Round robin:** `req` = 4'hF held, each bit dropped after its own ack and reasserted one cycle later.
  - Ack order is 0, 1, 2, 3, 0.
  - Successive ack pulses are 33 cycles apart.
  - Each word equals the next golden 32-shift word.
- **Zero seed:** `seed_load` with `seed_data` = 0 mid-FILL.
  - The subsequent word sequence is identical to the sequence after reset.
- **Seed vs grant collision:** `seed_load` with `seed_data` = 32'hDEADBEEF on the same edge a READY grant would occur.
  - No `ack` on that edge.
  - Next `ack` comes 33 edges later with the golden word from seed DEADBEEF.
  - `rr` is unchanged.
- **Reset mid-operation:** assert `reset` during FILL at count 17 and during READY.
  - All outputs return to their reset values at once, and no partial word is ever granted.
- **Counter wrap:** force `words_issued` near 16'hFFFF with a shortened `SHIFTS` = 1 build.
  - 16'hFFFF is followed by 0, and grants continue normally.

Source files
------------

// File: rtl/prng_pkg.sv
// Shared definitions for the PRNG arbiter: LFSR width, taps, reset seed and FSM states.
package prng_pkg;

  localparam int unsigned LFSR_W = 32;

  localparam int unsigned TAP_A = 31;
  localparam int unsigned TAP_B = 21;
  localparam int unsigned TAP_C = 1;
  localparam int unsigned TAP_D = 0;

  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 32'd13;

  typedef enum logic {
    FILL,
    READY
  } state_e;

  // Fibonacci step: feedback enters at the MSB, register shifts toward bit 0.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] l);
    logic fb;
    fb = l[TAP_A] ^ l[TAP_B] ^ l[TAP_C] ^ l[TAP_D];
    return {fb, l[LFSR_W-1:1]};
  endfunction

endpackage

// File: rtl/prng_arbiter_if.sv
// Requester-side bus of the PRNG arbiter: requests, grants, granted word and reseed port.
interface prng_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
) ();
    import prng_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] ack;
    logic [LFSR_W-1:0]  rnd_data;
    logic               seed_load;
    logic [LFSR_W-1:0]  seed_data;
    logic               word_ready;
    logic [15:0]        words_issued;

    modport master (
        output req,
        output seed_load,
        output seed_data,
        input  ack,
        input  rnd_data,
        input  word_ready,
        input  words_issued
    );

    modport slave (
        input  req,
        input  seed_load,
        input  seed_data,
        output ack,
        output rnd_data,
        output word_ready,
        output words_issued
    );

endinterface

// File: rtl/lfsr32_core.sv
// 32-bit Fibonacci LFSR register with load and zero-seed substitution.
module lfsr32_core
    import prng_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              shift_en,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_data,
    output logic [LFSR_W-1:0] state
);

    // A zero load would lock the LFSR, so the reset seed stands in for it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= SEED;
        end else if (load) begin
            state <= (load_data == '0) ? SEED : load_data;
        end else if (shift_en) begin
            state <= lfsr_step(state);
        end
    end

endmodule

// File: rtl/prng_arbiter.sv
// Round-robin distribution of LFSR words to NUM_REQ requesters, SHIFTS shifts per word.
module prng_arbiter
    import prng_pkg::*;
#(
    parameter int unsigned       NUM_REQ = 4,
    parameter int unsigned       SHIFTS  = 32,
    parameter logic [LFSR_W-1:0] SEED    = DEFAULT_SEED
) (
    input  logic           clock,
    input  logic           reset,
    prng_arbiter_if.slave  bus
);

    localparam int unsigned RR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = 6;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [LFSR_W-1:0]  lfsr;
    logic [LFSR_W-1:0]  buf_q;
    logic [LFSR_W-1:0]  rnd_q;
    logic [RR_W-1:0]    rr_q;
    logic [NUM_REQ-1:0] ack_q;
    logic [15:0]        words_issued_q;

    logic               shift_en;
    logic               last_shift;
    logic               pick_vld;
    logic [RR_W-1:0]    pick_idx;
    logic [RR_W-1:0]    cand;
    logic [RR_W-1:0]    rr_next;

    assign shift_en   = (state_q == FILL) && !bus.seed_load;
    assign last_shift = (cnt_q == CNT_W'(SHIFTS - 1));

    lfsr32_core #(
        .SEED (SEED)
    ) u_lfsr (
        .clock     (clock),
        .reset     (reset),
        .shift_en  (shift_en),
        .load      (bus.seed_load),
        .load_data (bus.seed_data),
        .state     (lfsr)
    );

    // Scan downward so the candidate closest to rr_q is the one left standing.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = RR_W'((int'(rr_q) + k) % NUM_REQ);
            if (bus.req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
        rr_next = RR_W'((32'(pick_idx) + 32'd1) % NUM_REQ);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= FILL;
            cnt_q          <= '0;
            buf_q          <= '0;
            rnd_q          <= '0;
            rr_q           <= '0;
            ack_q          <= '0;
            words_issued_q <= '0;
        end else begin
            ack_q <= '0;
            if (bus.seed_load) begin
                // Reseed drops any pending word; rr and the grant count survive.
                state_q <= FILL;
                cnt_q   <= '0;
                buf_q   <= '0;
            end else begin
                case (state_q)
                    FILL: begin
                        if (last_shift) begin
                            buf_q   <= lfsr_step(lfsr);
                            cnt_q   <= '0;
                            state_q <= READY;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    READY: begin
                        if (pick_vld) begin
                            ack_q[pick_idx] <= 1'b1;
                            rnd_q           <= buf_q;
                            rr_q            <= rr_next;
                            words_issued_q  <= words_issued_q + 16'd1;
                            state_q         <= FILL;
                        end
                    end
                    default: state_q <= FILL;
                endcase
            end
        end
    end

    assign bus.ack          = ack_q;
    assign bus.rnd_data     = rnd_q;
    assign bus.word_ready   = (state_q == READY);
    assign bus.words_issued = words_issued_q;

endmodule

// File: tb/tb_prng_arbiter.sv
// Directed bench for prng_arbiter: grant table, reseed, reset and counter-wrap sequences.
module tb_prng_arbiter;
    import prng_pkg::*;

    logic clock  = 1'b0;
    logic reset  = 1'b1;
    logic reset2 = 1'b1;

    always #5 clock = ~clock;

    prng_arbiter_if #(.NUM_REQ(4)) bus ();
    prng_arbiter_if #(.NUM_REQ(4)) bus2 ();

    prng_arbiter #(
        .NUM_REQ (4),
        .SHIFTS  (32),
        .SEED    (32'd13)
    ) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    prng_arbiter #(
        .NUM_REQ (4),
        .SHIFTS  (1),
        .SEED    (32'd13)
    ) u_dut_short (
        .clock (clock),
        .reset (reset2),
        .bus   (bus2)
    );

    typedef struct {
        logic [3:0] req;
        logic [3:0] ack;
    } vec_t;

    vec_t        tbl[10];
    int          n_vec = 0;
    int          n_miss = 0;
    int          edge_no = 0;
    int          ref_edge = 0;
    logic [31:0] gold;
    logic [15:0] exp_issued;

    function automatic logic [31:0] step(input logic [31:0] l);
        return {l[31] ^ l[21] ^ l[1] ^ l[0], l[31:1]};
    endfunction

    function automatic logic [31:0] word_after(input logic [31:0] l, input int n);
        logic [31:0] s;
        s = l;
        for (int i = 0; i < n; i++) s = step(s);
        return s;
    endfunction

    task automatic tick();
        @(posedge clock);
        edge_no++;
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Hold r until a grant, compare it, then drop the granted bit for one cycle.
    task automatic do_grant(input string name, input logic [3:0] r, input logic [3:0] exp_ack);
        logic [3:0] a;
        int         gap;
        a = '0;
        bus.req = r;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus.ack != '0) begin
                a = bus.ack;
                break;
            end
        end
        gap = edge_no - ref_edge;
        gold = word_after(gold, 32);
        exp_issued = exp_issued + 16'd1;
        check({name, " ack"}, 32'(a), 32'(exp_ack));
        check({name, " gap"}, gap, 33);
        check({name, " rnd_data"}, bus.rnd_data, gold);
        check({name, " words_issued"}, 32'(bus.words_issued), 32'(exp_issued));
        ref_edge = edge_no;
        bus.req = r & ~a;
        tick();
        check({name, " ack pulse"}, 32'(bus.ack), 0);
        check({name, " word_ready low"}, 32'(bus.word_ready), 0);
    endtask

    task automatic wait_ready(input string name);
        for (int i = 0; i < 100; i++) begin
            if (bus.word_ready) break;
            tick();
        end
        check({name, " word_ready"}, 32'(bus.word_ready), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] gold2;
        logic [15:0] exp2;
        logic [3:0]  a2;
        int          ref2;

        tbl[0] = '{4'hF, 4'b0001};
        tbl[1] = '{4'hF, 4'b0010};
        tbl[2] = '{4'hF, 4'b0100};
        tbl[3] = '{4'hF, 4'b1000};
        tbl[4] = '{4'hF, 4'b0001};
        tbl[5] = '{4'b1001, 4'b1000};
        tbl[6] = '{4'b1001, 4'b0001};
        tbl[7] = '{4'b0001, 4'b0001};
        tbl[8] = '{4'b0110, 4'b0010};
        tbl[9] = '{4'b0011, 4'b0001};

        bus.req = '0;
        bus.seed_load = 1'b0;
        bus.seed_data = '0;
        bus2.req = '0;
        bus2.seed_load = 1'b0;
        bus2.seed_data = '0;
        repeat (3) tick();

        check("reset ack", 32'(bus.ack), 0);
        check("reset rnd_data", bus.rnd_data, 0);
        check("reset word_ready", 32'(bus.word_ready), 0);
        check("reset words_issued", 32'(bus.words_issued), 0);

        // Single requester held from reset.
        bus.req = 4'b0100;
        reset = 1'b0;
        ref_edge = edge_no;
        gold = 32'd13;
        exp_issued = '0;
        repeat (31) tick();
        check("word_ready before edge 32", 32'(bus.word_ready), 0);
        tick();
        check("word_ready at edge 32", 32'(bus.word_ready), 1);
        do_grant("single", 4'b0100, 4'b0100);

        // Round-robin table from a fresh reset.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ref_edge = edge_no;
        gold = 32'd13;
        exp_issued = '0;
        for (int v = 0; v < 10; v++) begin
            do_grant($sformatf("rr%0d", v), tbl[v].req, tbl[v].ack);
        end

        // Zero seed mid-FILL restarts the post-reset sequence.
        repeat (9) tick();
        bus.seed_load = 1'b1;
        bus.seed_data = '0;
        tick();
        bus.seed_load = 1'b0;
        ref_edge = edge_no;
        gold = 32'd13;
        do_grant("zseed0", 4'b0001, 4'b0001);
        do_grant("zseed1", 4'b0001, 4'b0001);

        // Reseed on the edge that would have granted; rr stays at 1.
        bus.req = '0;
        wait_ready("idle");
        repeat (5) tick();
        check("idle stays ready", 32'(bus.word_ready), 1);
        check("idle no ack", 32'(bus.ack), 0);
        bus.req = 4'b0011;
        bus.seed_load = 1'b1;
        bus.seed_data = 32'hDEADBEEF;
        tick();
        bus.seed_load = 1'b0;
        check("coll no ack", 32'(bus.ack), 0);
        check("coll word_ready", 32'(bus.word_ready), 0);
        ref_edge = edge_no;
        gold = 32'hDEADBEEF;
        do_grant("coll", 4'b0011, 4'b0010);

        // Reset at fill count 17.
        bus.req = 4'b0100;
        repeat (16) tick();
        #3 reset = 1'b1;
        #1;
        check("rst fill ack", 32'(bus.ack), 0);
        check("rst fill rnd_data", bus.rnd_data, 0);
        check("rst fill word_ready", 32'(bus.word_ready), 0);
        check("rst fill words_issued", 32'(bus.words_issued), 0);
        tick();
        reset = 1'b0;
        ref_edge = edge_no;
        gold = 32'd13;
        exp_issued = '0;
        do_grant("rst_fill", 4'b0100, 4'b0100);

        // Reset while a word waits in READY.
        bus.req = '0;
        wait_ready("pre rst");
        #3 reset = 1'b1;
        #1;
        check("rst ready ack", 32'(bus.ack), 0);
        check("rst ready rnd_data", bus.rnd_data, 0);
        check("rst ready word_ready", 32'(bus.word_ready), 0);
        check("rst ready words_issued", 32'(bus.words_issued), 0);
        tick();
        reset = 1'b0;
        ref_edge = edge_no;
        gold = 32'd13;
        exp_issued = '0;
        do_grant("rst_ready", 4'b0010, 4'b0010);

        // SHIFTS=1 build: grant count forced near the top to show the wrap.
        bus2.req = 4'b0001;
        reset2 = 1'b0;
        ref2 = edge_no;
        gold2 = 32'd13;
        exp2 = '0;
        for (int g = 0; g < 8; g++) begin
            a2 = '0;
            for (int i = 0; i < 10; i++) begin
                tick();
                if (bus2.ack != '0) begin
                    a2 = bus2.ack;
                    break;
                end
            end
            gold2 = step(gold2);
            exp2 = exp2 + 16'd1;
            check($sformatf("wrap%0d ack", g), 32'(a2), 32'(4'b0001));
            check($sformatf("wrap%0d gap", g), edge_no - ref2, 2);
            check($sformatf("wrap%0d rnd_data", g), bus2.rnd_data, gold2);
            check($sformatf("wrap%0d words_issued", g), 32'(bus2.words_issued), 32'(exp2));
            ref2 = edge_no;
            if (g == 2) begin
                force u_dut_short.words_issued_q = 16'hFFFE;
                #1;
                release u_dut_short.words_issued_q;
                exp2 = 16'hFFFE;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
